operand_fetch: RTL

//  Read-side client and write-side driver of the 32x32 register file. It accepts

---
 rtl/operand_fetch_pkg.sv | 16 +
 rtl/operand_fetch_if.sv | 48 ++++
 rtl/operand_fetch_bypass.sv | 56 +++++
 rtl/operand_fetch.sv | 125 ++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch block.
// Contents:
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default widths (must match the register file)
//   state_t                         : operand fetch FSM encoding
package operand_fetch_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Request, writeback and operand channels of the operand fetch block.
// Handshake rule for both the req and op channels: a transfer happens on a
// rising clock edge where valid & ready are both 1. The producer keeps valid
// and its payload steady until that edge; ready may depend combinationally on
// the consumer's state, valid never depends on ready.
// Signals:
//   req_valid/req_ready/req_left_addr/req_right_addr : operand request channel
//   wb_valid/wb_addr/wb_data                         : pipeline writeback (no handshake)
//   op_valid/op_ready/op_left/op_right               : operand pair to execute
// Modports:
//   master : request/writeback source and operand consumer (pipeline side)
//   slave  : the operand fetch block
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_left_addr;
  logic [ADDR_W-1:0] req_right_addr;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_left;
  logic [DATA_W-1:0] op_right;

  modport master (
    output req_valid, req_left_addr, req_right_addr,
    output wb_valid, wb_addr, wb_data,
    output op_ready,
    input  req_ready, op_valid, op_left, op_right
  );

  modport slave (
    input  req_valid, req_left_addr, req_right_addr,
    input  wb_valid, wb_addr, wb_data,
    input  op_ready,
    output req_ready, op_valid, op_left, op_right
  );

endinterface

// File: rtl/operand_fetch_bypass.sv
// operand_bypass: per-operand writeback forwarding.
// The register file samples its old contents on the accept edge, so a
// writeback to the same register in the accept cycle would be missed. This
// block captures that writeback at accept and substitutes it for the file
// output during FETCH.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   accept_i          : request accepted on this edge
//   src_addr_i        : source register being accepted
//   wb_valid_i/wb_addr_i/wb_data_i : writeback in the accept cycle
//   rf_out_i          : registered register file read data (valid in FETCH)
//   operand_o         : forwarded or file value, consumed in FETCH
module operand_bypass
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              accept_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [DATA_W-1:0] rf_out_i,
  output logic [DATA_W-1:0] operand_o
);

  logic              fwd_q;
  logic              fwd_d;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] fwd_data_d;

  always_comb begin
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    if (accept_i) begin
      fwd_d      = wb_valid_i & (wb_addr_i == src_addr_i);
      fwd_data_d = wb_data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign operand_o = fwd_q ? fwd_data_q : rf_out_i;

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: read-side client and write-side driver of a 32x32 register
// file with 1-cycle registered reads. Accepts operand requests, reads both
// sources, forwards same-cycle writebacks, and holds the registered operand
// pair until execute consumes it. Request accepted at end of cycle t gives
// op_valid in cycle t+2.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   bus                 : request / writeback / operand channels (slave side)
//   rf_left_addr/rf_right_addr : register file read addresses
//   rf_dest_addr/rf_in/rf_write_enable : register file write port
//   rf_left_out/rf_right_out   : register file read data (1-cycle latency)
//   dbg_state           : current FSM state
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                clock,
  input  logic                reset,
  operand_fetch_if.slave      bus,
  output logic [ADDR_W-1:0]   rf_left_addr,
  output logic [ADDR_W-1:0]   rf_right_addr,
  output logic [ADDR_W-1:0]   rf_dest_addr,
  output logic [DATA_W-1:0]   rf_in,
  output logic                rf_write_enable,
  input  logic [DATA_W-1:0]   rf_left_out,
  input  logic [DATA_W-1:0]   rf_right_out,
  output state_t              dbg_state
);

  state_t            state_q;
  logic              op_valid_q;
  logic [DATA_W-1:0] op_left_q;
  logic [DATA_W-1:0] op_right_q;
  logic [ADDR_W-1:0] left_addr_q;
  logic [ADDR_W-1:0] right_addr_q;

  logic              req_ready;
  logic              accept;
  logic [DATA_W-1:0] left_operand;
  logic [DATA_W-1:0] right_operand;

  // Ready in IDLE, or in HOLD when the held pair leaves on this same edge.
  assign req_ready = ~reset & ((state_q == IDLE) | ((state_q == HOLD) & bus.op_ready));
  assign accept    = bus.req_valid & req_ready;

  // Present the incoming addresses in the accept cycle so the file's
  // registered read lines up with FETCH; otherwise keep the last accepted ones.
  assign rf_left_addr  = req_ready ? bus.req_left_addr  : left_addr_q;
  assign rf_right_addr = req_ready ? bus.req_right_addr : right_addr_q;

  assign rf_dest_addr    = bus.wb_addr;
  assign rf_in           = bus.wb_data;
  assign rf_write_enable = bus.wb_valid & ~reset;

  operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_left (
    .clock      (clock),
    .reset      (reset),
    .accept_i   (accept),
    .src_addr_i (rf_left_addr),
    .wb_valid_i (bus.wb_valid),
    .wb_addr_i  (bus.wb_addr),
    .wb_data_i  (bus.wb_data),
    .rf_out_i   (rf_left_out),
    .operand_o  (left_operand)
  );

  operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_right (
    .clock      (clock),
    .reset      (reset),
    .accept_i   (accept),
    .src_addr_i (rf_right_addr),
    .wb_valid_i (bus.wb_valid),
    .wb_addr_i  (bus.wb_addr),
    .wb_data_i  (bus.wb_data),
    .rf_out_i   (rf_right_out),
    .operand_o  (right_operand)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      op_valid_q   <= 1'b0;
      op_left_q    <= '0;
      op_right_q   <= '0;
      left_addr_q  <= '0;
      right_addr_q <= '0;
    end else begin
      if (accept) begin
        left_addr_q  <= bus.req_left_addr;
        right_addr_q <= bus.req_right_addr;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= FETCH;
        end
        FETCH: begin
          state_q    <= HOLD;
          op_valid_q <= 1'b1;
          op_left_q  <= left_operand;
          op_right_q <= right_operand;
        end
        HOLD: begin
          if (bus.op_ready) begin
            op_valid_q <= 1'b0;
            // req_ready is 1 here, so req_valid means accepted.
            state_q    <= bus.req_valid ? FETCH : IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          op_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.op_valid  = op_valid_q;
  assign bus.op_left   = op_left_q;
  assign bus.op_right  = op_right_q;
  assign dbg_state     = state_q;

endmodule
